div_iter: RTL

DIV_ITER -- requirements
Module: div_iter

---
 rtl/div_iter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider (signed or unsigned), one quotient bit per clock.
// Define DIV_EARLY_SKIP_EN to skip the dividend magnitude's leading zeros at accept time.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_by_zero_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state;
  // Dividend bits leave at the top while quotient bits enter at the bottom.
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo_q;
  logic             neg_rem_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_init;
  logic [CNT_W-1:0] cnt_init;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign dvd_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign dvs_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign dvd_mag = dvd_neg ? -opdata1_i : opdata1_i;
  assign dvs_mag = dvs_neg ? -opdata2_i : opdata2_i;

`ifdef DIV_EARLY_SKIP_EN
  function automatic logic [CNT_W-1:0] lead_zeros(input logic [WIDTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = CNT_W'(WIDTH - 1);
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) n = CNT_W'(WIDTH - 1 - i);
    end
    return n;
  endfunction

  logic [CNT_W-1:0] lz;

  // Skipped leading zeros would only produce zero quotient bits, so start the count past them.
  assign lz       = lead_zeros(dvd_mag);
  assign dvd_init = dvd_mag << lz;
  assign cnt_init = lz;
`else
  assign dvd_init = dvd_mag;
  assign cnt_init = '0;
`endif

  assign trial   = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = trial - {1'b0, dvs_q};
  assign quo_fix = neg_quo_q ? -dvd_q : dvd_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  assign busy_o  = (state == CALC) || (state == FIX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      dvd_q         <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      cnt_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      result_o      <= '0;
      ready_o       <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !annul_i) begin
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
            if (opdata2_i == '0) begin
              result_o      <= {opdata1_i, {WIDTH{1'b1}}};
              ready_o       <= 1'b1;
              div_by_zero_o <= 1'b1;
              state         <= DONE;
            end else begin
              dvd_q <= dvd_init;
              dvs_q <= dvs_mag;
              rem_q <= '0;
              cnt_q <= cnt_init;
              state <= CALC;
            end
          end
        end

        CALC: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            // A borrow out of the trial subtract means the divisor did not fit: keep the old remainder.
            dvd_q <= {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
            rem_q <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state <= FIX;
          end
        end

        FIX: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            result_o      <= {rem_fix, quo_fix};
            ready_o       <= 1'b1;
            div_by_zero_o <= 1'b0;
            state         <= DONE;
          end
        end

        DONE: begin
          if (!start_i) begin
            ready_o       <= 1'b0;
            div_by_zero_o <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
